trig_seq_engine: RTL and testbench

Parametrised sequential trigger engine, the next generation of the scope's trigger path. It selects arm, A and B event sources from an N-wide source vector and runs an arm → A → delay → B-count → fire → holdoff sequence. It emits a one-cycle trigger pulse toward the acquisition `trig` block and the trigger-out pins. Optional pattern matching across all sources is provided as an extra virtual source.

---
 rtl/trig_seq_pkg.sv | 40 ++++
 rtl/trig_seq_engine_edge_sel.sv | 58 +++++
 rtl/trig_seq_engine.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_trig_seq_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_seq_pkg.sv
// ----------------------------------------------------------------------------
// trig_seq_pkg
// Shared definitions for the sequential trigger engine: state encoding,
// sequence-mode constants, edge-polarity constants and small decode helpers.
// ----------------------------------------------------------------------------
package trig_seq_pkg;

    // Fixed encodings: software reads state_o directly.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ARM = 3'd1,
        ST_WAIT_A   = 3'd2,
        ST_DELAY    = 3'd3,
        ST_WAIT_B   = 3'd4,
        ST_HOLDOFF  = 3'd5,
        ST_DONE     = 3'd6
    } trig_state_e;

    // seq_mode values; bit0 enables the delay stage, bit1 the B-count stage.
    localparam logic [1:0] MODE_A            = 2'd0;
    localparam logic [1:0] MODE_A_DELAY      = 2'd1;
    localparam logic [1:0] MODE_A_BCNT       = 2'd2;
    localparam logic [1:0] MODE_A_DELAY_BCNT = 2'd3;

    localparam logic POL_FALL = 1'b0;
    localparam logic POL_RISE = 1'b1;

    function automatic logic mode_has_delay(input logic [1:0] mode);
        return |(mode & MODE_A_DELAY);
    endfunction

    function automatic logic mode_has_bcnt(input logic [1:0] mode);
        return |(mode & MODE_A_BCNT);
    endfunction

    function automatic logic state_is_armed(input trig_state_e st);
        return (st == ST_WAIT_A) || (st == ST_DELAY) || (st == ST_WAIT_B);
    endfunction

endpackage

// File: rtl/trig_seq_engine_edge_sel.sv
// ----------------------------------------------------------------------------
// trig_edge_sel
// Selects one event source, registers it, and detects a rising or falling
// edge against the previous registered value.
//
// Ports:
//   rxclk, rst_n : clock, asynchronous active-low reset
//   src_in       : raw sources (synchronous to rxclk)
//   pat_match    : pattern-match virtual source (index N_SRC)
//   sel          : source index; indices above N_SRC read constant 0
//   pol          : POL_RISE / POL_FALL
//   edge_det     : combinational edge flag, valid one cycle after the source
//                  change is sampled
// ----------------------------------------------------------------------------
module trig_edge_sel
    import trig_seq_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter int SEL_W = 5
) (
    input  logic             rxclk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] src_in,
    input  logic             pat_match,
    input  logic [SEL_W-1:0] sel,
    input  logic             pol,
    output logic             edge_det
);

    logic mux_d;
    logic cur_q;
    logic prev_q;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path can hold a stale value and infer a latch.
    always_comb begin
        mux_d = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) mux_d = src_in[i];
        end
        if (sel == SEL_W'(N_SRC)) mux_d = pat_match;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others (prev_q gets the old cur_q).
    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            cur_q  <= mux_d;
            prev_q <= cur_q;
        end
    end

    assign edge_det = (pol == POL_RISE) ? (cur_q & ~prev_q) : (~cur_q & prev_q);

endmodule

// File: rtl/trig_seq_engine.sv
// ----------------------------------------------------------------------------
// trig_seq_engine
// Sequential trigger engine: arm -> A -> delay -> B-count -> fire -> holdoff.
// Emits a one-cycle trigger pulse and counts triggers fired.
//
// Optional feature macro: TRIG_SEQ_PATTERN_EN
//   defined   : registered pattern comparator over src_in, selectable as
//               source index N_SRC (one extra cycle of latency)
//   undefined : pat_val / pat_mask unused, index N_SRC reads 0
//
// Ports:
//   rxclk, rst_n             : clock, asynchronous active-low reset
//   enable                   : run; config latched on rise, low forces IDLE
//   src_in                   : trigger sources (synchronous to rxclk)
//   arm_en                   : 1 = wait for arm event before A
//   arm_sel/a_sel/b_sel      : source indices
//   arm_pol/a_pol/b_pol      : 1 = rising, 0 = falling
//   seq_mode                 : 0 A, 1 A+delay, 2 A+B count, 3 A+delay+B count
//   delay_cyc/b_count/holdoff_cyc : stage lengths
//   single                   : stop in DONE after one trigger
//   rearm                    : DONE -> re-enter the arm/A wait
//   pat_val/pat_mask         : pattern compare value / compare mask
//   trig_out                 : one-cycle trigger pulse
//   armed                    : high in WAIT_A, DELAY, WAIT_B
//   state_o                  : current state encoding
//   trig_cnt                 : trigger count, wraps
// ----------------------------------------------------------------------------
module trig_seq_engine
    import trig_seq_pkg::*;
#(
    parameter int N_SRC = 16,
    parameter int SEL_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             rxclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_SRC-1:0] src_in,
    input  logic             arm_en,
    input  logic [SEL_W-1:0] arm_sel,
    input  logic [SEL_W-1:0] a_sel,
    input  logic [SEL_W-1:0] b_sel,
    input  logic             arm_pol,
    input  logic             a_pol,
    input  logic             b_pol,
    input  logic [1:0]       seq_mode,
    input  logic [CNT_W-1:0] delay_cyc,
    input  logic [CNT_W-1:0] b_count,
    input  logic [CNT_W-1:0] holdoff_cyc,
    input  logic             single,
    input  logic             rearm,
    input  logic [N_SRC-1:0] pat_val,
    input  logic [N_SRC-1:0] pat_mask,
    output logic             trig_out,
    output logic             armed,
    output logic [2:0]       state_o,
    output logic [31:0]      trig_cnt
);

    trig_state_e      state_q, state_d;
    logic             enable_q;
    logic             cfg_load;

    // Latched configuration
    logic             arm_en_q;
    logic [SEL_W-1:0] arm_sel_q, a_sel_q, b_sel_q;
    logic             arm_pol_q, a_pol_q, b_pol_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] delay_q, bcount_q, holdoff_q;
    logic             single_q;

    logic [CNT_W-1:0] cnt_q;    // DELAY / HOLDOFF cycle counter
    logic [CNT_W-1:0] bcnt_q;   // B edges counted in WAIT_B
    logic             trig_q;
    logic             armed_q;
    logic [31:0]      trig_cnt_q;

    logic             fire;
    logic             trig_d;
    logic             armed_d;
    logic             cnt_clr;

    logic [CNT_W-1:0] delay_last, holdoff_last, b_last;
    trig_state_e      resume_st;  // where a fire / holdoff returns to
    trig_state_e      rearm_st;

    logic             arm_edge, a_edge, b_edge;
    logic             pat_q;

    // While IDLE the selectors follow the live inputs so that the edge
    // registers already hold the chosen source when config is latched;
    // otherwise switching sources would look like a spurious edge.
    logic             in_idle;
    logic [SEL_W-1:0] arm_sel_eff, a_sel_eff, b_sel_eff;
    logic             arm_pol_eff, a_pol_eff, b_pol_eff;

    assign in_idle     = (state_q == ST_IDLE);
    assign arm_sel_eff = in_idle ? arm_sel : arm_sel_q;
    assign a_sel_eff   = in_idle ? a_sel   : a_sel_q;
    assign b_sel_eff   = in_idle ? b_sel   : b_sel_q;
    assign arm_pol_eff = in_idle ? arm_pol : arm_pol_q;
    assign a_pol_eff   = in_idle ? a_pol   : a_pol_q;
    assign b_pol_eff   = in_idle ? b_pol   : b_pol_q;

    assign cfg_load = in_idle && enable && !enable_q;

    // ------------------------------------------------------------------
    // Pattern comparator (virtual source N_SRC)
    // ------------------------------------------------------------------
`ifdef TRIG_SEQ_PATTERN_EN
    logic [N_SRC-1:0] pat_val_q, pat_mask_q;
    logic [N_SRC-1:0] pat_val_eff, pat_mask_eff;

    assign pat_val_eff  = in_idle ? pat_val  : pat_val_q;
    assign pat_mask_eff = in_idle ? pat_mask : pat_mask_q;

    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_val_q  <= '0;
            pat_mask_q <= '0;
            pat_q      <= 1'b0;
        end else begin
            if (cfg_load) begin
                pat_val_q  <= pat_val;
                pat_mask_q <= pat_mask;
            end
            // src_in is already synchronous, so compare it directly.
            pat_q <= (((src_in ^ pat_val_eff) & pat_mask_eff) == '0);
        end
    end
`else
    logic unused_pat;
    assign unused_pat = ^{pat_val, pat_mask};
    assign pat_q      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Event edge selectors
    // ------------------------------------------------------------------
    trig_edge_sel #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_arm_sel (
        .rxclk     (rxclk),
        .rst_n     (rst_n),
        .src_in    (src_in),
        .pat_match (pat_q),
        .sel       (arm_sel_eff),
        .pol       (arm_pol_eff),
        .edge_det  (arm_edge)
    );

    trig_edge_sel #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_a_sel (
        .rxclk     (rxclk),
        .rst_n     (rst_n),
        .src_in    (src_in),
        .pat_match (pat_q),
        .sel       (a_sel_eff),
        .pol       (a_pol_eff),
        .edge_det  (a_edge)
    );

    trig_edge_sel #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_b_sel (
        .rxclk     (rxclk),
        .rst_n     (rst_n),
        .src_in    (src_in),
        .pat_match (pat_q),
        .sel       (b_sel_eff),
        .pol       (b_pol_eff),
        .edge_det  (b_edge)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign delay_last   = delay_q - 1'b1;
    assign holdoff_last = holdoff_q - 1'b1;
    assign b_last       = (bcount_q == '0) ? '0 : bcount_q - 1'b1;  // 0 acts as 1
    assign rearm_st     = arm_en_q ? ST_WAIT_ARM : ST_WAIT_A;
    assign resume_st    = single_q ? ST_DONE : rearm_st;

    // Each state only looks at its own event, which gives arm priority over
    // A and A priority over B when edges coincide.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_load) state_d = arm_en ? ST_WAIT_ARM : ST_WAIT_A;
                end
                ST_WAIT_ARM: begin
                    if (arm_edge) state_d = ST_WAIT_A;
                end
                ST_WAIT_A: begin
                    if (a_edge) begin
                        if (mode_has_delay(mode_q) && (delay_q != '0)) state_d = ST_DELAY;
                        else if (mode_has_bcnt(mode_q))                state_d = ST_WAIT_B;
                        else                                           fire    = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == delay_last) begin
                        if (mode_has_bcnt(mode_q)) state_d = ST_WAIT_B;
                        else                       fire    = 1'b1;
                    end
                end
                ST_WAIT_B: begin
                    if (b_edge && (bcnt_q == b_last)) fire = 1'b1;
                end
                ST_HOLDOFF: begin
                    if (cnt_q == holdoff_last) state_d = resume_st;
                end
                ST_DONE: begin
                    if (rearm) state_d = rearm_st;
                end
                default: state_d = ST_IDLE;
            endcase
            if (fire) state_d = (holdoff_q != '0) ? ST_HOLDOFF : resume_st;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        trig_d  = fire;
        armed_d = state_is_armed(state_d);
        cnt_clr = (state_d != state_q);
    end

    // ------------------------------------------------------------------
    // State, counters, config and output registers
    // ------------------------------------------------------------------
    // NOTE: config registers are reset too, even though they are always
    // loaded before use, so the block powers up in a known, X-free state.
    always_ff @(posedge rxclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            arm_en_q   <= 1'b0;
            arm_sel_q  <= '0;
            a_sel_q    <= '0;
            b_sel_q    <= '0;
            arm_pol_q  <= POL_FALL;
            a_pol_q    <= POL_FALL;
            b_pol_q    <= POL_FALL;
            mode_q     <= MODE_A;
            delay_q    <= '0;
            bcount_q   <= '0;
            holdoff_q  <= '0;
            single_q   <= 1'b0;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            trig_q     <= 1'b0;
            armed_q    <= 1'b0;
            trig_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            trig_q   <= trig_d;
            armed_q  <= armed_d;

            if (cfg_load) begin
                arm_en_q  <= arm_en;
                arm_sel_q <= arm_sel;
                a_sel_q   <= a_sel;
                b_sel_q   <= b_sel;
                arm_pol_q <= arm_pol;
                a_pol_q   <= a_pol;
                b_pol_q   <= b_pol;
                mode_q    <= seq_mode;
                delay_q   <= delay_cyc;
                bcount_q  <= b_count;
                holdoff_q <= holdoff_cyc;
                single_q  <= single;
            end

            // Any state change (including enable low -> IDLE) restarts counters.
            if (cnt_clr) begin
                cnt_q  <= '0;
                bcnt_q <= '0;
            end else begin
                if ((state_q == ST_DELAY) || (state_q == ST_HOLDOFF)) cnt_q <= cnt_q + 1'b1;
                if ((state_q == ST_WAIT_B) && b_edge) bcnt_q <= bcnt_q + 1'b1;
            end

            if (fire) trig_cnt_q <= trig_cnt_q + 1'b1;
        end
    end

    assign trig_out = trig_q;
    assign armed    = armed_q;
    assign state_o  = state_q;
    assign trig_cnt = trig_cnt_q;

endmodule

// File: tb/tb_trig_seq_engine.sv
// ----------------------------------------------------------------------------
// tb_trig_seq_engine
// Directed self-checking bench for trig_seq_engine. Cycle numbers below are
// counts of rxclk rising edges; an input driven just after edge c is "seen"
// in cycle c and a response in cycle c+2 is sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_trig_seq_engine;
    import trig_seq_pkg::*;

    localparam int N_SRC = 16;
    localparam int SEL_W = 5;
    localparam int CNT_W = 32;

    logic             rxclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [N_SRC-1:0] src_in = '0;
    logic             arm_en;
    logic [SEL_W-1:0] arm_sel, a_sel, b_sel;
    logic             arm_pol, a_pol, b_pol;
    logic [1:0]       seq_mode;
    logic [CNT_W-1:0] delay_cyc, b_count, holdoff_cyc;
    logic             single;
    logic             rearm = 1'b0;
    logic [N_SRC-1:0] pat_val, pat_mask;
    logic             trig_out;
    logic             armed;
    logic [2:0]       state_o;
    logic [31:0]      trig_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fire_q[$];

    trig_seq_engine #(.N_SRC(N_SRC), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .rxclk       (rxclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .src_in      (src_in),
        .arm_en      (arm_en),
        .arm_sel     (arm_sel),
        .a_sel       (a_sel),
        .b_sel       (b_sel),
        .arm_pol     (arm_pol),
        .a_pol       (a_pol),
        .b_pol       (b_pol),
        .seq_mode    (seq_mode),
        .delay_cyc   (delay_cyc),
        .b_count     (b_count),
        .holdoff_cyc (holdoff_cyc),
        .single      (single),
        .rearm       (rearm),
        .pat_val     (pat_val),
        .pat_mask    (pat_mask),
        .trig_out    (trig_out),
        .armed       (armed),
        .state_o     (state_o),
        .trig_cnt    (trig_cnt)
    );

    always #5 rxclk = ~rxclk;

    always @(posedge rxclk) cyc <= cyc + 1;

    // Record the cycle of every trigger pulse.
    always @(negedge rxclk) begin
        if (trig_out === 1'b1) fire_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge rxclk);
        #1;
    endtask

    task automatic cfg_defaults();
        arm_en      = 1'b0;
        arm_sel     = 5'd2;
        a_sel       = 5'd0;
        b_sel       = 5'd1;
        arm_pol     = POL_RISE;
        a_pol       = POL_RISE;
        b_pol       = POL_RISE;
        seq_mode    = MODE_A;
        delay_cyc   = '0;
        b_count     = '0;
        holdoff_cyc = '0;
        single      = 1'b0;
        pat_val     = '0;
        pat_mask    = '0;
    endtask

    task automatic engine_stop();
        enable = 1'b0;
        src_in = '0;
        step(3);
    endtask

    task automatic engine_start();
        enable = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        cfg_defaults();
        rst_n = 1'b0;
        #12;
        checks++; if (state_o !== 3'(ST_IDLE)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_o, ST_IDLE); end
        checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL reset_trig_out got=%b exp=0", trig_out); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%b exp=0", armed); end
        checks++; if (trig_cnt !== 32'd0) begin failures++; $display("FAIL reset_trig_cnt got=%0d exp=0", trig_cnt); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_mode0_single();
        int c0, c1;
        cfg_defaults();
        single = 1'b1;
        engine_start();
        checks++; if (state_o !== 3'(ST_WAIT_A)) begin failures++; $display("FAIL m0_wait_a got=%0d exp=%0d", state_o, ST_WAIT_A); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL m0_armed got=%b exp=1", armed); end
        fire_q.delete();
        src_in[0] = 1'b1; c0 = cyc;
        step(4);
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 2) begin failures++; $display("FAIL m0_fire_cycle got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 2); end
        checks++; if (trig_cnt !== 32'd1) begin failures++; $display("FAIL m0_trig_cnt got=%0d exp=1", trig_cnt); end
        checks++; if (state_o !== 3'(ST_DONE)) begin failures++; $display("FAIL m0_done got=%0d exp=%0d", state_o, ST_DONE); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL m0_done_armed got=%b exp=0", armed); end
        // A second edge in DONE must be ignored.
        src_in[0] = 1'b0; step(2); src_in[0] = 1'b1; step(4);
        checks++; if (fire_q.size() != 1) begin failures++; $display("FAIL m0_done_ignores got_n=%0d exp=1", fire_q.size()); end
        rearm = 1'b1; step(1); rearm = 1'b0; step(1);
        checks++; if (state_o !== 3'(ST_WAIT_A)) begin failures++; $display("FAIL m0_rearm got=%0d exp=%0d", state_o, ST_WAIT_A); end
        src_in[0] = 1'b0; step(2); src_in[0] = 1'b1; c1 = cyc;
        step(4);
        checks++; if (fire_q.size() != 2 || fire_q[1] != c1 + 2) begin failures++; $display("FAIL m0_rearm_fire got_n=%0d exp_cycle=%0d", fire_q.size(), c1 + 2); end
        checks++; if (trig_cnt !== 32'd2) begin failures++; $display("FAIL m0_rearm_cnt got=%0d exp=2", trig_cnt); end
    endtask

    task automatic test_mode1_delay();
        int c0;
        engine_stop();
        checks++; if (state_o !== 3'(ST_IDLE)) begin failures++; $display("FAIL m1_idle got=%0d exp=%0d", state_o, ST_IDLE); end
        checks++; if (trig_cnt !== 32'd2) begin failures++; $display("FAIL m1_cnt_held got=%0d exp=2", trig_cnt); end
        cfg_defaults();
        seq_mode  = MODE_A_DELAY;
        delay_cyc = 32'd5;
        engine_start();
        fire_q.delete();
        src_in[0] = 1'b1; c0 = cyc;
        step(3);
        checks++; if (state_o !== 3'(ST_DELAY)) begin failures++; $display("FAIL m1_delay_state got=%0d exp=%0d", state_o, ST_DELAY); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL m1_delay_armed got=%b exp=1", armed); end
        // A edge inside DELAY: must not restart or fire.
        src_in[0] = 1'b0; step(1); src_in[0] = 1'b1;
        step(8);
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 7) begin failures++; $display("FAIL m1_fire_cycle got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 7); end
        checks++; if (state_o !== 3'(ST_WAIT_A)) begin failures++; $display("FAIL m1_after got=%0d exp=%0d", state_o, ST_WAIT_A); end
    endtask

    task automatic test_mode3_arm_seq();
        int c0;
        engine_stop();
        cfg_defaults();
        arm_en    = 1'b1;
        seq_mode  = MODE_A_DELAY_BCNT;
        delay_cyc = 32'd3;
        b_count   = 32'd4;
        engine_start();
        checks++; if (state_o !== 3'(ST_WAIT_ARM)) begin failures++; $display("FAIL m3_wait_arm got=%0d exp=%0d", state_o, ST_WAIT_ARM); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL m3_arm_not_armed got=%b exp=0", armed); end
        // Arm and A together: only the arm counts.
        src_in[2] = 1'b1; src_in[0] = 1'b1;
        step(3);
        checks++; if (state_o !== 3'(ST_WAIT_A)) begin failures++; $display("FAIL m3_arm_priority got=%0d exp=%0d", state_o, ST_WAIT_A); end
        src_in[0] = 1'b0; step(2);
        fire_q.delete();
        c0 = cyc;
        // A rise at c0 together with the first B rise; B rises every 2 cycles.
        for (int i = 0; i < 16; i++) begin
            if (i == 0) src_in[0] = 1'b1;
            src_in[1] = (i % 2 == 0);
            step(1);
        end
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 12) begin failures++; $display("FAIL m3_fire_cycle got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 12); end
        checks++; if (state_o !== 3'(ST_WAIT_ARM)) begin failures++; $display("FAIL m3_back_to_arm got=%0d exp=%0d", state_o, ST_WAIT_ARM); end
        checks++; if (trig_cnt !== 32'd4) begin failures++; $display("FAIL m3_trig_cnt got=%0d exp=4", trig_cnt); end
    endtask

    task automatic test_holdoff();
        int c0, c1;
        engine_stop();
        cfg_defaults();
        holdoff_cyc = 32'd100;
        engine_start();
        fire_q.delete();
        c0 = cyc;
        for (int i = 0; i < 250; i++) begin
            src_in[0] = ((i % 10) < 5);
            step(1);
        end
        checks++; if (fire_q.size() != 3) begin failures++; $display("FAIL ho_count got=%0d exp=3", fire_q.size()); end
        else begin
            checks++; if (fire_q[0] != c0 + 2 || fire_q[1] != c0 + 112 || fire_q[2] != c0 + 222) begin failures++; $display("FAIL ho_cycles got=%0d,%0d,%0d exp=%0d,%0d,%0d", fire_q[0] - c0, fire_q[1] - c0, fire_q[2] - c0, 2, 112, 222); end
        end
        checks++; if (state_o !== 3'(ST_HOLDOFF)) begin failures++; $display("FAIL ho_state got=%0d exp=%0d", state_o, ST_HOLDOFF); end
        enable = 1'b0; step(1);
        checks++; if (state_o !== 3'(ST_IDLE)) begin failures++; $display("FAIL ho_disable got=%0d exp=%0d", state_o, ST_IDLE); end
        checks++; if (trig_cnt !== 32'd7) begin failures++; $display("FAIL ho_cnt_held got=%0d exp=7", trig_cnt); end
        // Fresh start after the abort: the old holdoff must not linger.
        src_in[0] = 1'b0; step(2);
        engine_start();
        src_in[0] = 1'b1; c1 = cyc;
        step(4);
        checks++; if (fire_q.size() != 4 || fire_q[3] != c1 + 2) begin failures++; $display("FAIL ho_restart got_n=%0d exp_cycle=%0d", fire_q.size(), c1 + 2); end
        checks++; if (trig_cnt !== 32'd8) begin failures++; $display("FAIL ho_restart_cnt got=%0d exp=8", trig_cnt); end
    endtask

    task automatic test_pattern();
        int c0;
        engine_stop();
        cfg_defaults();
        a_sel    = 5'd16;
        pat_mask = 16'h0003;
        pat_val  = 16'h0001;
        engine_start();
        fire_q.delete();
        src_in = 16'h0003; step(4);
        src_in = 16'h0F01; c0 = cyc; step(4);
        src_in = 16'h0003; step(4);
        src_in = 16'h0002; step(4);
`ifdef TRIG_SEQ_PATTERN_EN
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 3) begin failures++; $display("FAIL pat_fire got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 3); end
`else
        checks++; if (fire_q.size() != 0) begin failures++; $display("FAIL pat_disabled got_n=%0d exp=0", fire_q.size()); end
`endif
        // Out-of-range index reads constant 0.
        engine_stop();
        a_sel = 5'd20;
        engine_start();
        fire_q.delete();
        for (int i = 0; i < 8; i++) begin
            src_in = (i % 2 == 0) ? '1 : '0;
            step(2);
        end
        checks++; if (fire_q.size() != 0) begin failures++; $display("FAIL sel_out_of_range got_n=%0d exp=0", fire_q.size()); end
    endtask

    task automatic test_mode2_reset();
        int c0;
        engine_stop();
        cfg_defaults();
        seq_mode = MODE_A_BCNT;
        b_count  = 32'd2;
        engine_start();
        fire_q.delete();
        src_in[0] = 1'b1; c0 = cyc;
        step(4); src_in[1] = 1'b1;
        step(2); src_in[1] = 1'b0;
        step(2); src_in[1] = 1'b1;
        step(4);
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 10) begin failures++; $display("FAIL m2_fire_cycle got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 10); end
        src_in[0] = 1'b0; step(2); src_in[0] = 1'b1; step(3);
        checks++; if (state_o !== 3'(ST_WAIT_B)) begin failures++; $display("FAIL m2_wait_b got=%0d exp=%0d", state_o, ST_WAIT_B); end
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL m2_wait_b_armed got=%b exp=1", armed); end
        #3; rst_n = 1'b0; #1;
        checks++; if (state_o !== 3'(ST_IDLE) || armed !== 1'b0 || trig_out !== 1'b0 || trig_cnt !== 32'd0) begin failures++; $display("FAIL async_reset got state=%0d armed=%b trig=%b cnt=%0d exp all 0", state_o, armed, trig_out, trig_cnt); end
        enable = 1'b0; src_in = '0;
        #2; rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_cnt_wrap();
        int c0;
        cfg_defaults();
        seq_mode = MODE_A_BCNT;
        b_count  = 32'd0;   // behaves as 1
        engine_start();
        dut.trig_cnt_q = 32'hFFFF_FFFF;
        step(1);
        checks++; if (trig_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", trig_cnt); end
        fire_q.delete();
        src_in[0] = 1'b1; c0 = cyc;
        step(3); src_in[1] = 1'b1;
        step(4);
        checks++; if (fire_q.size() != 1 || fire_q[0] != c0 + 5) begin failures++; $display("FAIL wrap_bcount0 got_n=%0d first=%0d exp=%0d", fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : -1, c0 + 5); end
        checks++; if (trig_cnt !== 32'd0) begin failures++; $display("FAIL wrap_cnt got=%h exp=0", trig_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0_single();
        test_mode1_delay();
        test_mode3_arm_seq();
        test_holdoff();
        test_pattern();
        test_mode2_reset();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
